// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: blank pattern, hex font table and segment bit positions.
package seg7_pkg;

  // Cathode pattern with every segment off (active low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bit positions inside a {g,f,e,d,c,b,a} segment word.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low hex glyphs, indexed by nibble value, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free frame
// snapshot, leading-zero blanking and registered active-low outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                slot_end;
  logic                load_pending;
  logic                frame_load;
  logic [4*DIGITS-1:0] snap_val;
  logic [DIGITS-1:0]   snap_dp;

  logic [3:0]          nib_p0;
  logic [6:0]          font_p0;
  logic [DIGITS-1:0]   blank_mask_p0;
  logic                blanked_p0;

  // Digit k (k > 0) is blankable when it and every more significant nibble are zero.
  function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [4*DIGITS-1:0] v);
    logic run;
    lz_blank_mask = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run & (v[4*k +: 4] == 4'h0);
      if (k != 0) lz_blank_mask[k] = run;
    end
  endfunction

  assign slot_end   = (presc == CNT_LAST);
  // A pending post-reset load and a frame-wrap load in the same cycle merge into one.
  assign frame_load = load_pending | (slot_end & (idx == IDX_LAST));

  // Refresh prescaler and digit-select ring.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Frame snapshot of value and decimal points, taken only at frame boundaries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snap_val     <= '0;
      snap_dp      <= '0;
      load_pending <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= frame_load;
      if (frame_load) begin
        snap_val     <= value;
        snap_dp      <= dp_in;
        load_pending <= 1'b0;
      end
    end
  end

  // Stage p0: select the active digit from the snapshot and decide blanking.
  always_comb begin
    nib_p0        = snap_val[4*idx +: 4];
    blank_mask_p0 = lz_blank_mask(snap_val);
    blanked_p0    = blank_lz & blank_mask_p0[idx];
  end

  hex_to_seg7 u_font (
    .nibble (nib_p0),
    .seg_n  (font_p0)
  );

  // Stage p1: registered drive outputs, one clock behind the index and snapshot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= blanked_p0 ? '1 : ~(DIGITS'(1) << idx);
      seg_n <= font_p0;
      dp_n  <= blanked_p0 ? 1'b1 : ~snap_dp[idx];
    end
  end

endmodule
